// File: rtl/gc_tx_scheduler.sv
// gc_tx_scheduler: arbitrates key, label, table and mask sources into one registered output stream
module gc_tx_scheduler #(
   parameter int S      = 20,
   parameter int K      = 128,
   parameter int MAXRUN = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         key_v,
   output logic         key_rdy,
   input  logic [K-1:0] key_d0,
   input  logic [K-1:0] key_d1,
   input  logic         lbl_v,
   output logic         lbl_rdy,
   input  logic [1:0]   lbl_en,
   input  logic [S-1:0] lbl_i0,
   input  logic [S-1:0] lbl_i1,
   input  logic [K-1:0] lbl_d0,
   input  logic [K-1:0] lbl_d1,
   input  logic         gt_v,
   output logic         gt_rdy,
   input  logic [S-1:0] gt_i,
   input  logic [K-1:0] gt_d0,
   input  logic [K-1:0] gt_d1,
   input  logic         msk_v,
   output logic         msk_rdy,
   input  logic [K-1:0] msk_d0,
   input  logic [K-1:0] msk_d1,
   output logic         out_v,
   input  logic         out_rdy,
   output logic [2:0]   out_tag,
   output logic [S-1:0] out_i0,
   output logic [S-1:0] out_i1,
   output logic [K-1:0] out_d0,
   output logic [K-1:0] out_d1,
   output logic [S-1:0] lbl_cnt,
   output logic [S-1:0] gt_cnt,
   output logic         done,
   output logic         err
);
   localparam int RW = $clog2(MAXRUN + 1);

   typedef enum logic [1:0] {IDLE, KEYS, STREAM, DONE} state_t;

   state_t        r_state, w_next;
   logic          r_out_v, r_err;
   logic [2:0]    r_tag;
   logic [S-1:0]  r_i0, r_i1, r_lbl_cnt, r_gt_cnt;
   logic [K-1:0]  r_d0, r_d1;
   logic [RW-1:0] r_run;
   logic          w_can, w_gk, w_gl, w_gg, w_gm;
   logic          w_xk, w_xl, w_xg, w_xm, w_bad, w_load, w_start;

   assign w_xk    = key_v & key_rdy;
   assign w_xl    = lbl_v & lbl_rdy;
   assign w_xg    = gt_v & gt_rdy;
   assign w_xm    = msk_v & msk_rdy;
   assign w_bad   = w_xl & (lbl_en == 2'b00);
   assign w_load  = w_xk | w_xg | w_xm | (w_xl & ~w_bad);
   // a finished session may only restart once its last mask has drained
   assign w_start = start & ((r_state == IDLE) | ((r_state == DONE) & ~r_out_v));

   assign out_v   = r_out_v;
   assign out_tag = r_tag;
   assign out_i0  = r_i0;
   assign out_i1  = r_i1;
   assign out_d0  = r_d0;
   assign out_d1  = r_d1;
   assign lbl_cnt = r_lbl_cnt;
   assign gt_cnt  = r_gt_cnt;
   assign err     = r_err;

   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;

   // next-state: session walks keys -> stream -> done
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_start ? KEYS : IDLE;
         KEYS:    w_next = w_xk ? STREAM : KEYS;
         STREAM:  w_next = w_xm ? DONE : STREAM;
         DONE:    w_next = w_start ? KEYS : DONE;
         default: w_next = IDLE;
      endcase
   end

   // grants: label beats table unless the waiting table record has hit its run limit
   always_comb begin
      w_can   = ~r_out_v | out_rdy;
      w_gk    = r_state == KEYS;
      w_gg    = (r_state == STREAM) & gt_v & (~lbl_v | (r_run == RW'(MAXRUN)));
      w_gl    = (r_state == STREAM) & lbl_v & ~w_gg;
      w_gm    = (r_state == STREAM) & ~lbl_v & ~gt_v;
      key_rdy = w_gk & w_can;
      lbl_rdy = w_gl & w_can;
      gt_rdy  = w_gg & w_can;
      msk_rdy = w_gm & w_can;
      done    = (r_state == DONE) & ~r_out_v;
   end

   // single output register stage, holds while stalled
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_out_v <= 1'b0;
         r_tag   <= 3'b000;
         r_i0    <= '1;
         r_i1    <= '1;
         r_d0    <= '0;
         r_d1    <= '0;
      end else begin
         r_out_v <= w_load | (r_out_v & ~out_rdy);
         if (w_xk) begin
            r_tag <= 3'b001;
            r_i0  <= '1;
            r_i1  <= '1;
            r_d0  <= key_d0;
            r_d1  <= key_d1;
         end
         if (w_xg) begin
            r_tag <= 3'b010;
            r_i0  <= {gt_i[S-2:0], 1'b0};
            r_i1  <= {gt_i[S-2:0], 1'b1};
            r_d0  <= gt_d0;
            r_d1  <= gt_d1;
         end
         if (w_xm) begin
            r_tag <= 3'b011;
            r_i0  <= '1;
            r_i1  <= '1;
            r_d0  <= msk_d0;
            r_d1  <= msk_d1;
         end
         if (w_xl & ~w_bad) begin
            r_tag <= {1'b1, lbl_en};
            r_i0  <= lbl_i0;
            r_i1  <= lbl_i1;
            r_d0  <= lbl_d0;
            r_d1  <= lbl_d1;
         end
      end

   // record counters, starvation run counter and sticky error
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_lbl_cnt <= '0;
         r_gt_cnt  <= '0;
         r_run     <= '0;
         r_err     <= 1'b0;
      end else if (w_start) begin
         r_lbl_cnt <= '0;
         r_gt_cnt  <= '0;
         r_run     <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_xl & ~w_bad) r_lbl_cnt <= r_lbl_cnt + S'(1);
         if (w_xg) r_gt_cnt <= r_gt_cnt + S'(1);
         if (w_bad) r_err <= 1'b1;
         r_run <= (w_xg | ~gt_v) ? '0 : (w_xl & (r_run != RW'(MAXRUN))) ? r_run + RW'(1) : r_run;
      end
endmodule

// File: tb/tb_gc_tx_scheduler.sv
// tb_gc_tx_scheduler: directed scenario tests for gc_tx_scheduler
module tb_gc_tx_scheduler;
   localparam int S = 20, K = 128, MAXRUN = 4;
   localparam logic [S-1:0] ONES = '1;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic key_v, key_rdy, lbl_v, lbl_rdy, gt_v, gt_rdy, msk_v, msk_rdy, out_v, out_rdy, done, err;
   logic [1:0] lbl_en;
   logic [2:0] out_tag;
   logic [S-1:0] lbl_i0, lbl_i1, gt_i, out_i0, out_i1, lbl_cnt, gt_cnt;
   logic [K-1:0] key_d0, key_d1, lbl_d0, lbl_d1, gt_d0, gt_d1, msk_d0, msk_d1, out_d0, out_d1;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   gc_tx_scheduler #(.S(S), .K(K), .MAXRUN(MAXRUN)) dut (
      .clk(clk), .rst(rst), .start(start),
      .key_v(key_v), .key_rdy(key_rdy), .key_d0(key_d0), .key_d1(key_d1),
      .lbl_v(lbl_v), .lbl_rdy(lbl_rdy), .lbl_en(lbl_en), .lbl_i0(lbl_i0), .lbl_i1(lbl_i1),
      .lbl_d0(lbl_d0), .lbl_d1(lbl_d1),
      .gt_v(gt_v), .gt_rdy(gt_rdy), .gt_i(gt_i), .gt_d0(gt_d0), .gt_d1(gt_d1),
      .msk_v(msk_v), .msk_rdy(msk_rdy), .msk_d0(msk_d0), .msk_d1(msk_d1),
      .out_v(out_v), .out_rdy(out_rdy), .out_tag(out_tag), .out_i0(out_i0), .out_i1(out_i1),
      .out_d0(out_d0), .out_d1(out_d1),
      .lbl_cnt(lbl_cnt), .gt_cnt(gt_cnt), .done(done), .err(err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      key_v = 1; lbl_v = 1; gt_v = 1; msk_v = 1;
      rst = 1;
      #2;
      total++; if (out_v !== 1'b0) begin bad++; $display("FAIL rst_out_v: got %b want 0", out_v); end
      total++; if (out_tag !== 3'b000) begin bad++; $display("FAIL rst_tag: got %b want 000", out_tag); end
      total++; if (out_i0 !== ONES || out_i1 !== ONES) begin bad++; $display("FAIL rst_idx: got %h/%h want all ones", out_i0, out_i1); end
      total++; if (out_d0 !== '0 || out_d1 !== '0) begin bad++; $display("FAIL rst_data: got %h/%h want 0", out_d0, out_d1); end
      total++; if (lbl_cnt !== '0 || gt_cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", lbl_cnt, gt_cnt); end
      total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_flags: got done=%b err=%b want 0/0", done, err); end
      total++; if ({key_rdy, lbl_rdy, gt_rdy, msk_rdy} !== 4'b0) begin bad++; $display("FAIL rst_rdy: got %b want 0000", {key_rdy, lbl_rdy, gt_rdy, msk_rdy}); end
      tick;
      rst = 0;
      tick;
      tick;
      total++; if ({key_rdy, lbl_rdy, gt_rdy, msk_rdy} !== 4'b0) begin bad++; $display("FAIL idle_rdy: got %b want 0000", {key_rdy, lbl_rdy, gt_rdy, msk_rdy}); end
      key_v = 0; lbl_v = 0; gt_v = 0; msk_v = 0;
   endtask

   task automatic test_session_basic;
      start = 1;
      tick;
      start = 0;
      key_v = 1; key_d0 = 128'h1; key_d1 = 128'h2; out_rdy = 1;
      #1;
      total++; if (key_rdy !== 1'b1) begin bad++; $display("FAIL keys_rdy: got %b want 1", key_rdy); end
      tick;
      key_v = 0;
      total++; if (out_v !== 1'b1 || out_tag !== 3'b001) begin bad++; $display("FAIL key_out: got v=%b tag=%b want 1/001", out_v, out_tag); end
      total++; if (out_d0 !== 128'h1 || out_d1 !== 128'h2 || out_i0 !== ONES) begin bad++; $display("FAIL key_data: got %h/%h/%h want 1/2/fffff", out_d0, out_d1, out_i0); end
      #1;
      total++; if (msk_rdy !== 1'b1 || key_rdy !== 1'b0) begin bad++; $display("FAIL stream_state: got msk_rdy=%b key_rdy=%b want 1/0", msk_rdy, key_rdy); end
      tick;
      total++; if (out_v !== 1'b0) begin bad++; $display("FAIL key_drain: got %b want 0", out_v); end
   endtask

   task automatic test_starvation;
      logic [9:0] pat;
      pat = 10'b0111101111;
      lbl_v = 1; lbl_en = 2'b11; lbl_i0 = 1; lbl_i1 = 2; lbl_d0 = 3; lbl_d1 = 4;
      gt_v = 1; gt_i = 5; gt_d0 = 6; gt_d1 = 7;
      for (int i = 0; i < 10; i++) begin
         #1;
         total++; if (lbl_rdy !== pat[i] || gt_rdy !== !pat[i]) begin bad++; $display("FAIL starve_grant[%0d]: got l=%b g=%b want l=%b", i, lbl_rdy, gt_rdy, pat[i]); end
         @(posedge clk);
         #1;
         total++; if (out_tag !== (pat[i] ? 3'b111 : 3'b010)) begin bad++; $display("FAIL starve_tag[%0d]: got %b want %b", i, out_tag, pat[i] ? 3'b111 : 3'b010); end
         if (!pat[i]) begin
            total++; if (out_i0 !== 20'd10 || out_i1 !== 20'd11) begin bad++; $display("FAIL starve_gt_idx[%0d]: got %0d/%0d want 10/11", i, out_i0, out_i1); end
         end
      end
      lbl_v = 0; gt_v = 0;
      tick;
      total++; if (out_v !== 1'b0 || lbl_cnt !== 20'd8 || gt_cnt !== 20'd2) begin bad++; $display("FAIL starve_cnt: got v=%b l=%0d g=%0d want 0/8/2", out_v, lbl_cnt, gt_cnt); end
   endtask

   task automatic test_backpressure;
      lbl_v = 1; lbl_en = 2'b01; lbl_i0 = 20'h123; lbl_d0 = 128'hAB; out_rdy = 1;
      tick;
      lbl_d0 = 128'hCD; gt_v = 1; out_rdy = 0;
      total++; if (out_v !== 1'b1 || out_tag !== 3'b101 || out_d0 !== 128'hAB) begin bad++; $display("FAIL bp_load: got v=%b tag=%b d0=%h want 1/101/ab", out_v, out_tag, out_d0); end
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if ({key_rdy, lbl_rdy, gt_rdy, msk_rdy} !== 4'b0) begin bad++; $display("FAIL bp_rdy[%0d]: got %b want 0000", i, {key_rdy, lbl_rdy, gt_rdy, msk_rdy}); end
         tick;
         total++; if (out_v !== 1'b1 || out_d0 !== 128'hAB || out_i0 !== 20'h123) begin bad++; $display("FAIL bp_hold[%0d]: got v=%b d0=%h i0=%h want 1/ab/123", i, out_v, out_d0, out_i0); end
      end
      lbl_v = 0; gt_v = 0; out_rdy = 1;
      tick;
      total++; if (out_v !== 1'b0 || lbl_cnt !== 20'd9) begin bad++; $display("FAIL bp_once: got v=%b l=%0d want 0/9", out_v, lbl_cnt); end
   endtask

   task automatic test_start_ignored;
      msk_v = 1; msk_d0 = 128'h55; msk_d1 = 128'h66; out_rdy = 1;
      #1;
      total++; if (msk_rdy !== 1'b1) begin bad++; $display("FAIL msk_rdy: got %b want 1", msk_rdy); end
      tick;
      msk_v = 0;
      total++; if (out_tag !== 3'b011 || out_i0 !== ONES || out_d0 !== 128'h55 || done !== 1'b0) begin bad++; $display("FAIL msk_out: got tag=%b i0=%h d0=%h done=%b want 011/fffff/55/0", out_tag, out_i0, out_d0, done); end
      out_rdy = 0; start = 1;
      tick;
      start = 0;
      total++; if (lbl_cnt !== 20'd9 || done !== 1'b0) begin bad++; $display("FAIL start_ignored: got l=%0d done=%b want 9/0", lbl_cnt, done); end
      out_rdy = 1;
      tick;
      total++; if (out_v !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL done_drain: got v=%b done=%b want 0/1", out_v, done); end
   endtask

   task automatic test_mask_gating;
      start = 1;
      tick;
      start = 0;
      total++; if (lbl_cnt !== '0 || gt_cnt !== '0 || done !== 1'b0) begin bad++; $display("FAIL start_clear: got l=%0d g=%0d done=%b want 0/0/0", lbl_cnt, gt_cnt, done); end
      key_v = 1;
      tick;
      key_v = 0; lbl_v = 1; lbl_en = 2'b11;
      for (int i = 0; i < 6; i++) tick;
      lbl_v = 0; gt_v = 1; gt_i = 1;
      tick;
      tick;
      msk_v = 1; gt_i = 7;
      #1;
      total++; if (msk_rdy !== 1'b0 || gt_rdy !== 1'b1) begin bad++; $display("FAIL msk_gate: got msk_rdy=%b gt_rdy=%b want 0/1", msk_rdy, gt_rdy); end
      tick;
      gt_v = 0;
      total++; if (out_tag !== 3'b010 || out_i0 !== 20'd14 || out_i1 !== 20'd15) begin bad++; $display("FAIL gt7_out: got tag=%b i=%0d/%0d want 010/14/15", out_tag, out_i0, out_i1); end
      #1;
      total++; if (msk_rdy !== 1'b1) begin bad++; $display("FAIL msk_ungate: got %b want 1", msk_rdy); end
      tick;
      msk_v = 0;
      total++; if (out_tag !== 3'b011 || done !== 1'b0) begin bad++; $display("FAIL msk2_out: got tag=%b done=%b want 011/0", out_tag, done); end
      tick;
      total++; if (done !== 1'b1 || lbl_cnt !== 20'd6 || gt_cnt !== 20'd3) begin bad++; $display("FAIL msk_done: got done=%b l=%0d g=%0d want 1/6/3", done, lbl_cnt, gt_cnt); end
   endtask

   task automatic test_illegal_label;
      start = 1;
      tick;
      start = 0; key_v = 1;
      tick;
      key_v = 0;
      tick;
      lbl_v = 1; lbl_en = 2'b00;
      #1;
      total++; if (lbl_rdy !== 1'b1) begin bad++; $display("FAIL ill_rdy: got %b want 1", lbl_rdy); end
      tick;
      lbl_v = 0;
      total++; if (out_v !== 1'b0 || lbl_cnt !== '0 || err !== 1'b1) begin bad++; $display("FAIL ill_label: got v=%b l=%0d err=%b want 0/0/1", out_v, lbl_cnt, err); end
      tick;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
   endtask

   task automatic test_reset_midstream;
      lbl_v = 1; lbl_en = 2'b10; out_rdy = 0;
      tick;
      total++; if (out_v !== 1'b1 || out_tag !== 3'b110) begin bad++; $display("FAIL mid_load: got v=%b tag=%b want 1/110", out_v, out_tag); end
      key_v = 1; gt_v = 1;
      #2;
      rst = 1;
      #1;
      total++; if (out_v !== 1'b0 || {key_rdy, lbl_rdy, gt_rdy, msk_rdy} !== 4'b0) begin bad++; $display("FAIL mid_rst: got v=%b rdy=%b want 0/0000", out_v, {key_rdy, lbl_rdy, gt_rdy, msk_rdy}); end
      total++; if (err !== 1'b0 || out_tag !== 3'b000 || out_i0 !== ONES) begin bad++; $display("FAIL mid_rst_regs: got err=%b tag=%b i0=%h want 0/000/fffff", err, out_tag, out_i0); end
      #3;
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick;
         total++; if (out_v !== 1'b0 || {key_rdy, lbl_rdy, gt_rdy, msk_rdy} !== 4'b0) begin bad++; $display("FAIL post_rst_idle[%0d]: got v=%b rdy=%b want 0/0000", i, out_v, {key_rdy, lbl_rdy, gt_rdy, msk_rdy}); end
      end
      lbl_v = 0; gt_v = 0; start = 1;
      tick;
      start = 0;
      #1;
      total++; if (key_rdy !== 1'b1) begin bad++; $display("FAIL restart_keys: got %b want 1", key_rdy); end
      key_v = 0;
   endtask

   initial begin
      key_v = 0; lbl_v = 0; gt_v = 0; msk_v = 0; out_rdy = 0;
      key_d0 = '0; key_d1 = '0; lbl_en = 2'b00; lbl_i0 = '0; lbl_i1 = '0; lbl_d0 = '0; lbl_d1 = '0;
      gt_i = '0; gt_d0 = '0; gt_d1 = '0; msk_d0 = '0; msk_d1 = '0;
      #1;
      test_reset;
      test_session_basic;
      test_starvation;
      test_backpressure;
      test_start_ignored;
      test_mask_gating;
      test_illegal_label;
      test_reset_midstream;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gc_tx_scheduler.md
GC_TX_SCHEDULER -- requirements
Module: gc_tx_scheduler

Interface
REQ-001 The block SHALL have parameters: S, 20, index width; K, 128, label width; MAXRUN, 4, max consecutive label grants while a table record waits.
REQ-002 The block SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high; start in 1 begin session.
REQ-003 The block SHALL have key-source ports: key_v in 1; key_rdy out 1; key_d0, key_d1 in K (R, AES key).
REQ-004 The block SHALL have label-source ports: lbl_v in 1; lbl_rdy out 1; lbl_en in 2 (bit0 port0 valid, bit1 port1 valid); lbl_i0, lbl_i1 in S; lbl_d0, lbl_d1 in K.
REQ-005 The block SHALL have table-source ports: gt_v in 1; gt_rdy out 1; gt_i in S (table row); gt_d0, gt_d1 in K.
REQ-006 The block SHALL have mask-source ports: msk_v in 1; msk_rdy out 1; msk_d0, msk_d1 in K.
REQ-007 The block SHALL have output ports: out_v out 1; out_rdy in 1; out_tag out 3; out_i0, out_i1 out S; out_d0, out_d1 out K.
REQ-008 The block SHALL have status ports: lbl_cnt out S; gt_cnt out S; done out 1; err out 1 (sticky).

Function
REQ-009 The block SHALL implement states IDLE, KEYS, STREAM, DONE; start is honoured only in IDLE or DONE and moves the FSM to KEYS, clearing lbl_cnt, gt_cnt, run counter and err.
REQ-010 IDLE/DONE: all *_rdy SHALL be 0.
REQ-011 KEYS: only key source eligible; on key accept, FSM SHALL move to STREAM.
REQ-012 STREAM: label, table, mask sources eligible; mask eligible only when lbl_v=0 and gt_v=0; on mask accept, FSM SHALL move to DONE.
REQ-013 Priority in STREAM SHALL be label over table, except table wins when gt_v=1 and run==MAXRUN.
REQ-014 Run counter SHALL increment on each label accept while gt_v=1, clear on table accept or whenever gt_v=0, and saturate at MAXRUN.
REQ-015 Accept condition: at most one source is granted per cycle; *_rdy = grant & (~out_v | out_rdy); transfer = *_v & *_rdy.
REQ-016 Output SHALL be a single register stage: load on transfer, out_v=1 the cycle after transfer; out_v clears on out_v&out_rdy with no new transfer; contents hold stable while out_v=1 and out_rdy=0.
REQ-017 Encoding: key tag 001, i0=i1=all-ones, d0=key_d0, d1=key_d1; table tag 010, i0=2*gt_i, i1=2*gt_i+1 (truncated to S bits); mask tag 011, i0=i1=all-ones; label tag {1,lbl_en}, i/d from label port.
REQ-018 Label accept with lbl_en=00 SHALL be consumed, not forwarded, not counted, and set err.
REQ-019 lbl_cnt SHALL increment by 1 per forwarded label record; gt_cnt per table record; both wrap modulo 2^S.
REQ-020 done SHALL be 1 exactly while FSM is in DONE and out_v=0 (last mask drained).
REQ-021 start asserted in DONE while out_v=1 SHALL be ignored until drained.

Reset
REQ-022 On rst the block SHALL immediately force FSM=IDLE, out_v=0, out_tag=000, out_i0=out_i1=all-ones, out_d0=out_d1=0, all counters 0, run=0, done=0, err=0, all *_rdy=0, regardless of in-flight transfers.

Verification
REQ-023 Session basic: start, key_v with d0=0x1, d1=0x2, out_rdy=1 -> next cycle out_v=1, tag 001, d0=0x1, d1=0x2; FSM in STREAM.
REQ-024 Starvation: lbl_v and gt_v held 1, out_rdy=1 -> grant order L,L,L,L,G,L,L,L,L,G; gt_i=5 record emits i0=10, i1=11.
REQ-025 Backpressure: out_rdy=0 for 3 cycles with out_v=1 -> all *_rdy=0, outputs unchanged; out_rdy=1 -> record delivered once, no loss or duplication.
REQ-026 Mask gating: msk_v=1 with gt_v=1 -> msk_rdy=0 until gt_v drops; mask accept -> tag 011, done=1 after drain; 6 labels and 3 tables sent -> lbl_cnt=6, gt_cnt=3.
REQ-027 Illegal label: lbl_en=00 accepted -> no out_v, lbl_cnt unchanged, err=1 until next start.
REQ-028 Reset mid-stream: rst asserted while out_v=1 -> out_v=0 and rdy=0 asynchronously; after release, FSM=IDLE and stays until start.
